spi_mem_responder: RTL and testbench

SPI mode-0 target that answers the same READ/WRITE byte protocol our SPI controller issues to external flash/RAM: command byte, 16-bit address, then auto-incrementing data bytes. It holds a small internal byte memory and serves as an on-chip stand-in for the external SPI RAM. Uses include bench co-simulation against the SPI controller, loop-back self-test, and a debug target behind one of the `outputs` chip selects. All SPI inputs are oversampled on the system clock; the block has no SCLK-domain logic.

---
 rtl/spi_mem_responder.sv | 145 ++++++++++++++
 tb/tb_spi_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target with a resettable byte memory: cmd 0x03 reads and 0x02 writes, each
// followed by a 16-bit address and auto-incrementing data bytes. SPI pins are oversampled on clk.
module spi_mem_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_READ, S_WRITE, S_IGNORE
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic            r_sclk_d;
  logic [2:0]      r_bit_cnt;
  logic [6:0]      r_rx_sr;
  logic [7:0]      r_cmd, r_addr_hi, r_tx_sr;
  logic [AW-1:0]   r_addr, r_wr_addr;
  logic            r_miso, r_wr_strobe;
  logic [7:0]      r_dbg_data;
  logic [7:0]      r_mem [DEPTH];

  logic            w_cs_high, w_rise, w_fall, w_byte_done, w_commit;
  logic [7:0]      w_rx_byte;
  logic [AW-1:0]   w_addr_new;

  assign w_cs_high   = r_cs_sync[1];
  assign w_rise      = r_sclk_sync[1] & ~r_sclk_d;
  assign w_fall      = ~r_sclk_sync[1] & r_sclk_d;
  assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_sr, r_mosi_sync[1]};
  assign w_addr_new  = AW'({r_addr_hi, w_rx_byte});
  // A byte finishing in the same cycle that cs_n is seen high is still committed.
  assign w_commit    = w_byte_done && (r_state == S_WRITE);

  assign miso      = r_miso;
  assign miso_oe   = ~r_cs_sync[1];
  assign busy      = (r_state != S_IDLE);
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign dbg_data  = r_dbg_data;
  assign dbg_state = r_state;

  // cs_n synchroniser resets to the deselected level so miso_oe stays low out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_cs_sync   <= {r_cs_sync[0], cs_n};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_cs_high) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_CMD;
        S_CMD:     if (w_byte_done)
                     w_next = (w_rx_byte == 8'h03 || w_rx_byte == 8'h02) ? S_ADDR_HI : S_IGNORE;
        S_ADDR_HI: if (w_byte_done) w_next = S_ADDR_LO;
        S_ADDR_LO: if (w_byte_done) w_next = (r_cmd == 8'h03) ? S_READ : S_WRITE;
        default:   w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_rx_sr     <= '0;
      r_cmd       <= '0;
      r_addr_hi   <= '0;
      r_tx_sr     <= '0;
      r_addr      <= '0;
      r_wr_addr   <= '0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_dbg_data  <= '0;
    end else begin
      r_wr_strobe <= w_commit;
      r_dbg_data  <= r_mem[dbg_addr];
      if (w_cs_high) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx_sr   <= w_rx_byte[6:0];
      end
      if (w_byte_done && r_state == S_CMD)     r_cmd     <= w_rx_byte;
      if (w_byte_done && r_state == S_ADDR_HI) r_addr_hi <= w_rx_byte;
      // Reads preload the first byte and advance; writes keep the address until commit.
      if (w_byte_done && r_state == S_ADDR_LO) begin
        r_tx_sr <= r_mem[w_addr_new];
        r_addr  <= (r_cmd == 8'h03) ? w_addr_new + AW'(1) : w_addr_new;
      end else if (w_byte_done && r_state == S_READ) begin
        r_tx_sr <= r_mem[r_addr];
        r_addr  <= r_addr + AW'(1);
      end else if (w_commit) begin
        r_wr_addr <= r_addr;
        r_addr    <= r_addr + AW'(1);
      end
      if (w_cs_high || r_state != S_READ) begin
        r_miso <= 1'b0;
      end else if (w_fall) begin
        r_miso  <= r_tx_sr[7];
        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_addr] <= w_rx_byte;
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: directed vector table, hand-written corner sequences and
// randomized transactions checked against a byte-array model of the memory protocol.
module tb_spi_mem_responder;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int HALF  = 5;

  logic          clk, rst, sclk, cs_n, mosi;
  logic          miso, miso_oe, busy, wr_strobe;
  logic [AW-1:0] wr_addr, dbg_addr;
  logic [7:0]    dbg_data;
  logic [2:0]    dbg_state;

  spi_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .busy(busy), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  logic [7:0]    tx_q[$];
  logic [7:0]    rx_q[$];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_wr_q[$];
  logic [AW-1:0] got_wr_q[$];
  logic [7:0]    ref_mem [DEPTH];
  logic          busy_at_end;

  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      wr_cnt++;
      got_wr_q.push_back(wr_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(HALF);
      r[i] = miso;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic run_txn();
    logic [7:0] r;
    rx_q.delete();
    cs_n = 1'b0;
    tick(HALF);
    foreach (tx_q[i]) begin
      xfer_bits(tx_q[i], 8, r);
      rx_q.push_back(r);
    end
    tick(HALF);
    busy_at_end = busy;
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [7:0] d);
    dbg_addr = a;
    tick(1);
    d = dbg_data;
  endtask

  // Protocol model: header bytes answer 0; data bytes walk the address modulo DEPTH.
  task automatic model_txn();
    logic [7:0] cmd;
    int a;
    exp_q.delete();
    exp_wr_q.delete();
    cmd = tx_q[0];
    a = int'({tx_q[1], tx_q[2]}) % DEPTH;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
    for (int k = 3; k < tx_q.size(); k++) begin
      if (cmd == 8'h03) begin
        exp_q.push_back(ref_mem[a]);
      end else begin
        exp_q.push_back(8'h00);
        if (cmd == 8'h02) begin
          ref_mem[a] = tx_q[k];
          exp_wr_q.push_back(AW'(a));
        end
      end
      a = (a + 1) % DEPTH;
    end
  endtask

  typedef struct packed {
    logic [7:0]      cmd;
    logic [15:0]     addr;
    logic [2:0]      n;
    logic [3:0][7:0] din;
    logic [3:0][7:0] exp;
    logic [2:0]      exp_wr;
    logic [7:0]      exp_last;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [7:0] cmd, input logic [15:0] addr, input logic [2:0] n,
                              input logic [31:0] din, input logic [31:0] exp,
                              input logic [2:0] exp_wr, input logic [7:0] exp_last);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.n = n;
    for (int k = 0; k < 4; k++) begin
      v.din[k] = din[31 - 8*k -: 8];
      v.exp[k] = exp[31 - 8*k -: 8];
    end
    v.exp_wr = exp_wr; v.exp_last = exp_last;
    return v;
  endfunction

  initial begin
    logic [7:0] r, d;
    int cnt0;

    vecs[0] = mk(8'h02, 16'h0010, 3'd2, 32'hA53C0000, 32'h00000000, 3'd2, 8'h11);
    vecs[1] = mk(8'h03, 16'h0010, 3'd2, 32'h00000000, 32'hA53C0000, 3'd0, 8'h11);
    vecs[2] = mk(8'h02, 16'h00FF, 3'd2, 32'h11220000, 32'h00000000, 3'd2, 8'h00);
    vecs[3] = mk(8'h03, 16'h12FF, 3'd2, 32'h00000000, 32'h11220000, 3'd0, 8'h00);
    vecs[4] = mk(8'h9F, 16'h0000, 3'd2, 32'h00000000, 32'h00000000, 3'd0, 8'h00);
    vecs[5] = mk(8'h02, 16'h0040, 3'd4, 32'hDEADBEEF, 32'h00000000, 3'd4, 8'h43);
    vecs[6] = mk(8'h03, 16'h0040, 3'd4, 32'h00000000, 32'hDEADBEEF, 3'd0, 8'h43);
    vecs[7] = mk(8'h03, 16'h00FE, 3'd3, 32'h00000000, 32'h00112200, 3'd0, 8'h43);

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; dbg_addr = '0;
    tick(3);
    check("rst_miso", 32'(miso), 0);
    check("rst_miso_oe", 32'(miso_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_strobe", 32'(wr_strobe), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_dbg_data", 32'(dbg_data), 0);
    rst = 1'b0;
    tick(3);
    check("idle_miso_oe", 32'(miso_oe), 0);
    check("idle_busy", 32'(busy), 0);

    // directed vector table
    for (int v = 0; v < NV; v++) begin
      tx_q.delete();
      tx_q.push_back(vecs[v].cmd);
      tx_q.push_back(vecs[v].addr[15:8]);
      tx_q.push_back(vecs[v].addr[7:0]);
      for (int k = 0; k < int'(vecs[v].n); k++) tx_q.push_back(vecs[v].din[k]);
      model_txn();
      cnt0 = wr_cnt;
      run_txn();
      check($sformatf("vec%0d_hdr_miso", v), 32'(rx_q[0] | rx_q[1] | rx_q[2]), 0);
      for (int k = 0; k < int'(vecs[v].n); k++)
        check($sformatf("vec%0d_miso%0d", v, k), 32'(rx_q[3 + k]), 32'(vecs[v].exp[k]));
      check($sformatf("vec%0d_busy_in", v), 32'(busy_at_end), 1);
      check($sformatf("vec%0d_busy_out", v), 32'(busy), 0);
      check($sformatf("vec%0d_wr_cnt", v), 32'(wr_cnt - cnt0), 32'(vecs[v].exp_wr));
      check($sformatf("vec%0d_wr_addr", v), 32'(wr_addr), 32'(vecs[v].exp_last));
    end
    peek(8'hFF, d); check("peek_ff", 32'(d), 32'h11);
    peek(8'h00, d); check("peek_00", 32'(d), 32'h22);

    // abort mid-byte
    cnt0 = wr_cnt;
    cs_n = 1'b0;
    tick(HALF);
    xfer_bits(8'h02, 8, r); xfer_bits(8'h00, 8, r); xfer_bits(8'h20, 8, r);
    xfer_bits(8'hFF, 5, r);
    check("abort_miso_oe", 32'(miso_oe), 1);
    check("abort_busy_before", 32'(busy), 1);
    cs_n = 1'b1;
    tick(2);
    check("abort_busy_2clk", 32'(busy), 1);
    tick(1);
    check("abort_busy_3clk", 32'(busy), 0);
    check("abort_miso_oe_off", 32'(miso_oe), 0);
    tick(8);
    check("abort_no_write", 32'(wr_cnt - cnt0), 0);
    peek(8'h20, d); check("abort_mem20", 32'(d), 0);

    // cs_n rises together with the 8th rise: byte still commits
    cnt0 = wr_cnt;
    cs_n = 1'b0;
    tick(HALF);
    xfer_bits(8'h02, 8, r); xfer_bits(8'h00, 8, r); xfer_bits(8'h30, 8, r);
    xfer_bits(8'h5A, 7, r);
    mosi = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    cs_n = 1'b1;
    tick(HALF);
    sclk = 1'b0;
    tick(8);
    ref_mem[8'h30] = 8'h5A;
    check("edge_commit_cnt", 32'(wr_cnt - cnt0), 1);
    check("edge_commit_addr", 32'(wr_addr), 32'h30);
    peek(8'h30, d); check("edge_commit_mem", 32'(d), 32'h5A);

    // async reset in the 2nd data byte of a read; cs_n held low across release
    dbg_addr = 8'h10;
    cs_n = 1'b0;
    tick(HALF);
    xfer_bits(8'h03, 8, r); xfer_bits(8'h00, 8, r); xfer_bits(8'h10, 8, r);
    xfer_bits(8'h00, 8, r);
    check("rstrd_first_byte", 32'(r), 32'hA5);
    xfer_bits(8'h00, 3, r);
    rst = 1'b1;
    #1;
    check("rstrd_miso", 32'(miso), 0);
    check("rstrd_miso_oe", 32'(miso_oe), 0);
    check("rstrd_busy", 32'(busy), 0);
    check("rstrd_wr_strobe", 32'(wr_strobe), 0);
    check("rstrd_wr_addr", 32'(wr_addr), 0);
    check("rstrd_dbg_data", 32'(dbg_data), 0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    tick(HALF);
    cnt0 = wr_cnt;
    xfer_bits(8'h02, 8, r); xfer_bits(8'h00, 8, r); xfer_bits(8'h50, 8, r);
    xfer_bits(8'h77, 8, r);
    tick(HALF);
    cs_n = 1'b1;
    tick(8);
    ref_mem[8'h50] = 8'h77;
    check("post_rst_wr_cnt", 32'(wr_cnt - cnt0), 1);
    check("post_rst_wr_addr", 32'(wr_addr), 32'h50);
    peek(8'h10, d); check("post_rst_mem10", 32'(d), 0);
    peek(8'h40, d); check("post_rst_mem40", 32'(d), 0);
    peek(8'hFF, d); check("post_rst_memff", 32'(d), 0);
    peek(8'h50, d); check("post_rst_mem50", 32'(d), 32'h77);

    // randomized transactions against the model
    for (int t = 0; t < 25; t++) begin
      logic [7:0] cmd;
      logic [15:0] a;
      int n, sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    cmd = 8'h02;
        2:       cmd = 8'h03;
        default: begin
          cmd = 8'($urandom_range(0, 255));
          if (cmd == 8'h02 || cmd == 8'h03) cmd = 8'h9F;
        end
      endcase
      a = 16'($urandom_range(0, 65535));
      if (t % 5 == 4) a = 16'hFFFE;
      n = $urandom_range(1, 4);
      tx_q.delete();
      tx_q.push_back(cmd); tx_q.push_back(a[15:8]); tx_q.push_back(a[7:0]);
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
      model_txn();
      got_wr_q.delete();
      run_txn();
      for (int k = 0; k < rx_q.size(); k++)
        check($sformatf("rnd%0d_miso%0d", t, k), 32'(rx_q[k]), 32'(exp_q[k]));
      check($sformatf("rnd%0d_wr_cnt", t), 32'(got_wr_q.size()), 32'(exp_wr_q.size()));
      for (int k = 0; k < exp_wr_q.size() && k < got_wr_q.size(); k++)
        check($sformatf("rnd%0d_wr_addr%0d", t, k), 32'(got_wr_q[k]), 32'(exp_wr_q[k]));
    end
    for (int p = 0; p < 16; p++) begin
      logic [AW-1:0] pa;
      pa = (p < 4) ? AW'(8'hFC + p) : AW'($urandom_range(0, DEPTH - 1));
      peek(pa, d);
      check($sformatf("rnd_peek_%0h", pa), 32'(d), 32'(ref_mem[pa]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
